// File: rtl/sequence_scheduler_if.sv
// Bus between the sequence scheduler and its controller / LUT RAM.
// Configuration, control, LUT read port and status are grouped here; the
// scheduler uses the slave view, the controlling side uses the master view.
interface sequence_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [63:0]           writepointer;
  logic [15:0]           step_size;
  logic [ADDR_WIDTH:0]   num_steps;
  logic [15:0]           repetitions;
  logic                  start;
  logic                  stop;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic [DATA_WIDTH-1:0] lut_data;
  logic [DATA_WIDTH-1:0] setpoint;
  logic                  setpoint_valid;
  logic [31:0]           step_counter;
  logic [15:0]           pass_counter;
  logic                  busy;
  logic                  done;
  logic                  config_error;

  modport master (
    output writepointer, step_size, num_steps, repetitions, start, stop, lut_data,
    input  lut_addr, setpoint, setpoint_valid, step_counter, pass_counter,
           busy, done, config_error
  );

  modport slave (
    input  writepointer, step_size, num_steps, repetitions, start, stop, lut_data,
    output lut_addr, setpoint, setpoint_valid, step_counter, pass_counter,
           busy, done, config_error
  );
endinterface

// File: rtl/sequence_scheduler.sv
// Plays a LUT-stored setpoint sequence against the ADC sample writepointer.
// A step ends when the running step_end falls strictly behind the
// writepointer; at most one step advances per cycle so a lagging step_end
// catches up without skipping entries. The LUT address is driven from the
// next-state value so the RAM's registered read lands exactly when the
// scheduler's lut_addr register takes that value: lut_data always holds the
// entry at the current lut_addr, which is what makes back-to-back advances
// during catch-up safe.
module sequence_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic aresetn,
  sequence_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREFETCH = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam logic [ADDR_WIDTH:0]   MAX_STEPS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   STEPS_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  logic [1:0]            state_reg, state_next;
  logic [63:0]           step_end_reg, step_end_next;
  logic [15:0]           step_size_reg, step_size_next;
  logic [ADDR_WIDTH:0]   num_steps_reg, num_steps_next;
  logic [15:0]           reps_reg, reps_next;
  logic [ADDR_WIDTH-1:0] index_reg, index_next;
  logic [ADDR_WIDTH-1:0] lut_addr_reg, lut_addr_next;
  logic [DATA_WIDTH-1:0] setpoint_reg, setpoint_next;
  logic                  valid_reg, valid_next;
  logic [31:0]           step_counter_reg, step_counter_next;
  logic [15:0]           pass_counter_reg, pass_counter_next;
  logic                  config_error_reg, config_error_next;

  logic                  cfg_ok;
  logic                  advance;
  logic [ADDR_WIDTH:0]   last_entry;
  logic                  last_index;
  logic                  last_addr;
  logic                  final_pass;

  assign cfg_ok     = (bus.step_size >= 16'd2) && (bus.num_steps != '0) &&
                      (bus.num_steps <= MAX_STEPS);
  assign advance    = (state_reg == RUN) && (step_end_reg < bus.writepointer);
  assign last_entry = num_steps_reg - STEPS_ONE;
  assign last_index = ({1'b0, index_reg} == last_entry);
  assign last_addr  = ({1'b0, lut_addr_reg} == last_entry);
  assign final_pass = (reps_reg != 16'd0) &&
                      (({1'b0, pass_counter_reg} + 17'd1) == {1'b0, reps_reg});

  // Next-state decode: stop overrides everything, start only from IDLE/DONE.
  always_comb begin
    state_next        = state_reg;
    step_end_next     = step_end_reg;
    step_size_next    = step_size_reg;
    num_steps_next    = num_steps_reg;
    reps_next         = reps_reg;
    index_next        = index_reg;
    lut_addr_next     = lut_addr_reg;
    setpoint_next     = setpoint_reg;
    valid_next        = valid_reg;
    step_counter_next = step_counter_reg;
    pass_counter_next = pass_counter_reg;
    config_error_next = config_error_reg;
    if (bus.stop) begin
      state_next    = IDLE;
      setpoint_next = '0;
      valid_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              config_error_next = 1'b0;
              step_counter_next = '0;
              pass_counter_next = '0;
              index_next        = '0;
              step_size_next    = bus.step_size;
              num_steps_next    = bus.num_steps;
              reps_next         = bus.repetitions;
              step_end_next     = bus.writepointer + {48'd0, bus.step_size};
              lut_addr_next     = '0;
              state_next        = PREFETCH;
            end else begin
              config_error_next = 1'b1;
            end
          end
        end
        PREFETCH: begin
          setpoint_next = bus.lut_data;
          valid_next    = 1'b1;
          lut_addr_next = (num_steps_reg == STEPS_ONE) ? '0 : ADDR_ONE;
          state_next    = RUN;
        end
        RUN: begin
          if (advance) begin
            step_end_next     = step_end_reg + {48'd0, step_size_reg};
            step_counter_next = step_counter_reg + 32'd1;
            lut_addr_next     = last_addr ? '0 : lut_addr_reg + ADDR_ONE;
            if (last_index) begin
              index_next        = '0;
              pass_counter_next = (pass_counter_reg == 16'hFFFF) ?
                                  pass_counter_reg : pass_counter_reg + 16'd1;
              if (final_pass) begin
                // Sequence finished: entry 0 is not presented again.
                state_next    = DONE;
                setpoint_next = '0;
                valid_next    = 1'b0;
              end else begin
                setpoint_next = bus.lut_data;
              end
            end else begin
              index_next    = index_reg + ADDR_ONE;
              setpoint_next = bus.lut_data;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      step_end_reg     <= '0;
      step_size_reg    <= '0;
      num_steps_reg    <= '0;
      reps_reg         <= '0;
      index_reg        <= '0;
      lut_addr_reg     <= '0;
      setpoint_reg     <= '0;
      valid_reg        <= 1'b0;
      step_counter_reg <= '0;
      pass_counter_reg <= '0;
      config_error_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      step_end_reg     <= step_end_next;
      step_size_reg    <= step_size_next;
      num_steps_reg    <= num_steps_next;
      reps_reg         <= reps_next;
      index_reg        <= index_next;
      lut_addr_reg     <= lut_addr_next;
      setpoint_reg     <= setpoint_next;
      valid_reg        <= valid_next;
      step_counter_reg <= step_counter_next;
      pass_counter_reg <= pass_counter_next;
      config_error_reg <= config_error_next;
    end
  end

  // The RAM registers this address at the same edge lut_addr_reg loads it.
  assign bus.lut_addr       = aresetn ? lut_addr_next : '0;
  assign bus.setpoint       = setpoint_reg;
  assign bus.setpoint_valid = valid_reg;
  assign bus.step_counter   = step_counter_reg;
  assign bus.pass_counter   = pass_counter_reg;
  assign bus.busy           = (state_reg == PREFETCH) || (state_reg == RUN);
  assign bus.done           = (state_reg == DONE);
  assign bus.config_error   = config_error_reg;
endmodule

// File: tb/tb_sequence_scheduler.sv
// Scoreboard bench for sequence_scheduler: stimulus pushes hand-computed
// output-change events (cycle + full status) into a queue, a monitor pops
// one entry whenever the DUT's visible status changes.
module tb_sequence_scheduler;
  logic clk = 1'b0;
  logic aresetn;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   wp_auto = 1'b0;
  bit   mon_en = 1'b0;
  logic [15:0] mem [0:1023];

  typedef struct packed {
    logic [15:0] sp;
    logic        v;
    logic [31:0] sc;
    logic [15:0] pc;
    logic        busy;
    logic        done;
    logic        cerr;
  } sig_t;

  typedef struct packed {
    logic [31:0] cyc;
    sig_t        s;
  } exp_t;

  exp_t exp_q[$];

  sequence_scheduler_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

  sequence_scheduler #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous LUT RAM with registered read.
  always @(posedge clk) bus.lut_data <= mem[bus.lut_addr];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (wp_auto) bus.writepointer = bus.writepointer + 64'd1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic expect_ev(input int c, input int sp, input bit v, input int sc,
                           input int pc, input bit b, input bit d, input bit ce);
    exp_t e;
    e.cyc    = c;
    e.s.sp   = sp[15:0];
    e.s.v    = v;
    e.s.sc   = sc;
    e.s.pc   = pc[15:0];
    e.s.busy = b;
    e.s.done = d;
    e.s.cerr = ce;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of visible status is one transaction.
  initial begin : monitor
    sig_t prev;
    sig_t cur;
    exp_t e;
    prev = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur.sp   = bus.setpoint;
      cur.v    = bus.setpoint_valid;
      cur.sc   = bus.step_counter;
      cur.pc   = bus.pass_counter;
      cur.busy = bus.busy;
      cur.done = bus.done;
      cur.cerr = bus.config_error;
      if (cur != prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: cyc=%0d sp=%0d v=%0d sc=%0d pc=%0d busy=%0d done=%0d cerr=%0d, expected no change",
                   cyc, cur.sp, cur.v, cur.sc, cur.pc, cur.busy, cur.done, cur.cerr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.s != cur) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d sp=%0d v=%0d sc=%0d pc=%0d busy=%0d done=%0d cerr=%0d, expected cyc=%0d sp=%0d v=%0d sc=%0d pc=%0d busy=%0d done=%0d cerr=%0d",
                     cyc, cur.sp, cur.v, cur.sc, cur.pc, cur.busy, cur.done, cur.cerr,
                     e.cyc, e.s.sp, e.s.v, e.s.sc, e.s.pc, e.s.busy, e.s.done, e.s.cerr);
          end else begin
            $display("event cyc=%0d sp=%0d v=%0d sc=%0d pc=%0d busy=%0d done=%0d cerr=%0d",
                     cyc, cur.sp, cur.v, cur.sc, cur.pc, cur.busy, cur.done, cur.cerr);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    int s;
    int tbl3 [3];
    int tbl4 [4];
    tbl3 = '{10, 20, 30};
    tbl4 = '{10, 20, 30, 40};
    for (int i = 0; i < 1024; i++) mem[i] = 16'd99;
    mem[0] = 16'd10; mem[1] = 16'd20; mem[2] = 16'd30; mem[3] = 16'd40;

    aresetn = 1'b0;
    bus.writepointer = 64'd0;
    bus.step_size    = 16'd0;
    bus.num_steps    = 11'd0;
    bus.repetitions  = 16'd0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    tick(3);

    // Reset state.
    @(negedge clk);
    check("rst_setpoint", 64'(bus.setpoint), 64'd0);
    check("rst_valid", 64'(bus.setpoint_valid), 64'd0);
    check("rst_step_counter", 64'(bus.step_counter), 64'd0);
    check("rst_pass_counter", 64'(bus.pass_counter), 64'd0);
    check("rst_lut_addr", 64'(bus.lut_addr), 64'd0);
    check("rst_busy_done_cerr", 64'({bus.busy, bus.done, bus.config_error}), 64'd0);
    aresetn = 1'b1;
    mon_en  = 1'b1;
    tick(1);

    // Basic playback: 10,20,30,40 each held 4 cycles, then DONE.
    bus.step_size = 16'd4; bus.num_steps = 11'd4; bus.repetitions = 16'd1;
    bus.writepointer = 64'd100; wp_auto = 1'b1; bus.start = 1'b1; s = cyc;
    expect_ev(s + 1,  0,  0, 0, 0, 1, 0, 0);
    expect_ev(s + 2,  10, 1, 0, 0, 1, 0, 0);
    expect_ev(s + 6,  20, 1, 1, 0, 1, 0, 0);
    expect_ev(s + 10, 30, 1, 2, 0, 1, 0, 0);
    expect_ev(s + 14, 40, 1, 3, 0, 1, 0, 0);
    expect_ev(s + 18, 0,  0, 4, 1, 0, 1, 0);
    wait_until(s + 22);

    // Infinite repetitions from DONE, 15 steps, then stop.
    bus.writepointer = 64'd200; bus.repetitions = 16'd0; bus.num_steps = 11'd3;
    bus.step_size = 16'd4; bus.start = 1'b1; s = cyc;
    expect_ev(s + 1, 0,  0, 0, 0, 1, 0, 0);
    expect_ev(s + 2, 10, 1, 0, 0, 1, 0, 0);
    for (int n = 1; n <= 15; n++) expect_ev(s + 2 + 4 * n, tbl3[n % 3], 1, n, n / 3, 1, 0, 0);
    wait_until(s + 63);
    bus.stop = 1'b1;
    expect_ev(s + 64, 0, 0, 15, 5, 0, 0, 0);
    wait_until(s + 66);
    wp_auto = 1'b0;

    // Config rejection: step_size=1, num_steps=0, num_steps=1025.
    bus.step_size = 16'd1; bus.num_steps = 11'd4; bus.repetitions = 16'd1;
    bus.start = 1'b1; s = cyc;
    expect_ev(s + 1, 0, 0, 15, 5, 0, 0, 1);
    wait_until(s + 2);
    bus.step_size = 16'd4; bus.num_steps = 11'd0; bus.start = 1'b1;
    tick(1);
    @(negedge clk);
    check("reject_zero_steps", 64'({bus.busy, bus.done, bus.config_error}), 64'd1);
    bus.num_steps = 11'd1025; bus.start = 1'b1;
    tick(1);
    @(negedge clk);
    check("reject_too_many_steps", 64'({bus.busy, bus.done, bus.config_error}), 64'd1);

    // Valid start clears config_error; catch-up after a jump of 20.
    bus.step_size = 16'd2; bus.num_steps = 11'd4; bus.repetitions = 16'd0;
    bus.writepointer = 64'd1000; bus.start = 1'b1; s = cyc;
    expect_ev(s + 1, 0,  0, 0, 0, 1, 0, 0);
    expect_ev(s + 2, 10, 1, 0, 0, 1, 0, 0);
    wait_until(s + 3);
    bus.writepointer = 64'd1001;
    wait_until(s + 4);
    bus.writepointer = 64'd1021;
    for (int n = 1; n <= 10; n++) expect_ev(s + 4 + n, tbl4[n % 4], 1, n, n / 4, 1, 0, 0);

    // Start and config changes during RUN are ignored.
    wait_until(s + 16);
    bus.step_size = 16'd3; bus.num_steps = 11'd2; bus.repetitions = 16'd1; bus.start = 1'b1;
    wait_until(s + 18);
    bus.writepointer = 64'd1023;
    expect_ev(s + 19, 40, 1, 11, 2, 1, 0, 0);

    // Reset during RUN clears everything.
    wait_until(s + 21);
    aresetn = 1'b0;
    expect_ev(s + 22, 0, 0, 0, 0, 0, 0, 0);
    wait_until(s + 22);
    aresetn = 1'b1;
    @(negedge clk);
    check("post_reset_lut_addr", 64'(bus.lut_addr), 64'd0);

    // start together with stop in IDLE: stays IDLE.
    bus.step_size = 16'd4; bus.num_steps = 11'd4; bus.repetitions = 16'd1;
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(1);
    @(negedge clk);
    check("start_stop_idle", 64'({bus.busy, bus.done}), 64'd0);

    // Single-step pass: lut_addr pinned at 0, DONE after 3 passes.
    tick(1);
    bus.step_size = 16'd5; bus.num_steps = 11'd1; bus.repetitions = 16'd3;
    bus.writepointer = 64'd2000; wp_auto = 1'b1; bus.start = 1'b1; s = cyc;
    expect_ev(s + 1,  0,  0, 0, 0, 1, 0, 0);
    expect_ev(s + 2,  10, 1, 0, 0, 1, 0, 0);
    expect_ev(s + 7,  10, 1, 1, 1, 1, 0, 0);
    expect_ev(s + 12, 10, 1, 2, 2, 1, 0, 0);
    expect_ev(s + 17, 0,  0, 3, 3, 0, 1, 0);
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      @(negedge clk);
      check("single_step_lut_addr", 64'(bus.lut_addr), 64'd0);
    end
    wait_until(s + 22);
    wp_auto = 1'b0;

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
